// File: rtl/bp_be_long_wb_sched.sv
// Long-pipe writeback scheduler: merges integer and FP result streams onto a
// single registered writeback port. Integer has fixed priority. A saturating
// starvation counter promotes FP so that it cannot wait forever.
module bp_be_long_wb_sched #(
   parameter int pkt_width_p    = 72,
   parameter int starve_limit_p = 4
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   flush_i,
   input  logic                   iwb_v_i,
   input  logic [pkt_width_p-1:0] iwb_pkt_i,
   output logic                   iwb_yumi_o,
   input  logic                   fwb_v_i,
   input  logic [pkt_width_p-1:0] fwb_pkt_i,
   output logic                   fwb_yumi_o,
   output logic                   wb_v_o,
   output logic [pkt_width_p-1:0] wb_pkt_o,
   output logic                   wb_fp_o,
   input  logic                   wb_ready_and_i
);

   localparam logic [3:0] starve_limit_lp = 4'(starve_limit_p);

   logic                   wb_v_q, wb_v_d;
   logic [pkt_width_p-1:0] wb_pkt_q, wb_pkt_d;
   logic                   wb_fp_q, wb_fp_d;
   logic [3:0]             starve_cnt_q, starve_cnt_d;
   logic                   promote_q, promote_d;
   logic                   load_en_s;
   logic                   grant_int_s;
   logic                   grant_fp_s;

   // Grant arbitration: only when the output slot can take a packet this cycle
   always_comb begin
      load_en_s   = ~reset_i & ~flush_i & (~wb_v_q | wb_ready_and_i);
      grant_int_s = 1'b0;
      grant_fp_s  = 1'b0;
      if (load_en_s) begin
         case ({iwb_v_i, fwb_v_i})
            2'b10:   grant_int_s = 1'b1;
            2'b01:   grant_fp_s  = 1'b1;
            2'b11: begin
               if (promote_q) begin
                  grant_fp_s = 1'b1;
               end else begin
                  grant_int_s = 1'b1;
               end
            end
            default: begin
               grant_int_s = 1'b0;
               grant_fp_s  = 1'b0;
            end
         endcase
      end else begin
         grant_int_s = 1'b0;
         grant_fp_s  = 1'b0;
      end
   end

   // Output register next state: flush empties the slot, a load replaces or empties it, otherwise hold
   always_comb begin
      wb_v_d   = wb_v_q;
      wb_pkt_d = wb_pkt_q;
      wb_fp_d  = wb_fp_q;
      if (flush_i) begin
         wb_v_d = 1'b0;
      end else if (load_en_s) begin
         if (grant_int_s) begin
            wb_v_d   = 1'b1;
            wb_pkt_d = iwb_pkt_i;
            wb_fp_d  = 1'b0;
         end else if (grant_fp_s) begin
            wb_v_d   = 1'b1;
            wb_pkt_d = fwb_pkt_i;
            wb_fp_d  = 1'b1;
         end else begin
            wb_v_d = 1'b0;
         end
      end else begin
         wb_v_d = wb_v_q;
      end
   end

   // Starvation tracking: count cycles FP waits (stalls included), saturating at the limit
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (flush_i | ~fwb_v_i | grant_fp_s) begin
         starve_cnt_d = 4'd0;
      end else if (starve_cnt_q < starve_limit_lp) begin
         starve_cnt_d = starve_cnt_q + 4'd1;
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
      promote_d = ~flush_i & (starve_cnt_d == starve_limit_lp);
   end

   // State registers with asynchronous active-high reset
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wb_v_q       <= 1'b0;
         wb_pkt_q     <= '0;
         wb_fp_q      <= 1'b0;
         starve_cnt_q <= 4'd0;
         promote_q    <= 1'b0;
      end else begin
         wb_v_q       <= wb_v_d;
         wb_pkt_q     <= wb_pkt_d;
         wb_fp_q      <= wb_fp_d;
         starve_cnt_q <= starve_cnt_d;
         promote_q    <= promote_d;
      end
   end

   assign iwb_yumi_o = grant_int_s;
   assign fwb_yumi_o = grant_fp_s;
   assign wb_v_o     = wb_v_q;
   assign wb_pkt_o   = wb_pkt_q;
   assign wb_fp_o    = wb_fp_q;

endmodule

// File: tb/tb_bp_be_long_wb_sched.sv
// Scoreboard bench for bp_be_long_wb_sched: a directed vector table drives the
// inputs and states the expected yumis/valid per cycle; granted packets are
// queued and a negedge monitor checks every delivered packet in order.
module tb_bp_be_long_wb_sched;

   localparam int W = 72;

   logic         clk_i = 1'b0;
   logic         reset_i;
   logic         flush_i;
   logic         iwb_v_i;
   logic [W-1:0] iwb_pkt_i;
   logic         iwb_yumi_o;
   logic         fwb_v_i;
   logic [W-1:0] fwb_pkt_i;
   logic         fwb_yumi_o;
   logic         wb_v_o;
   logic [W-1:0] wb_pkt_o;
   logic         wb_fp_o;
   logic         wb_ready_and_i;

   int n_checks = 0;
   int n_errors = 0;
   int icnt = 0;
   int fcnt = 0;
   logic [W:0] exp_q [$];
   logic [7:0] tbl [47];

   bp_be_long_wb_sched #(.pkt_width_p(W), .starve_limit_p(4)) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .flush_i        (flush_i),
      .iwb_v_i        (iwb_v_i),
      .iwb_pkt_i      (iwb_pkt_i),
      .iwb_yumi_o     (iwb_yumi_o),
      .fwb_v_i        (fwb_v_i),
      .fwb_pkt_i      (fwb_pkt_i),
      .fwb_yumi_o     (fwb_yumi_o),
      .wb_v_o         (wb_v_o),
      .wb_pkt_o       (wb_pkt_o),
      .wb_fp_o        (wb_fp_o),
      .wb_ready_and_i (wb_ready_and_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
      end
   endtask

   // Apply one table row for one cycle and check its combinational/valid expectations
   task automatic apply(input int k);
      logic [7:0] v;
      v = tbl[k];
      @(posedge clk_i);
      #1;
      iwb_v_i        = v[7];
      fwb_v_i        = v[6];
      wb_ready_and_i = v[5];
      flush_i        = v[4];
      iwb_pkt_i      = 72'h11 + 72'(icnt);
      fwb_pkt_i      = {8'hA5, 64'h0} + 72'(fcnt);
      #1;
      chk($sformatf("iwb_yumi[%0d]", k), {72'h0, iwb_yumi_o}, {72'h0, v[3]});
      chk($sformatf("fwb_yumi[%0d]", k), {72'h0, fwb_yumi_o}, {72'h0, v[2]});
      chk($sformatf("wb_v[%0d]", k), {72'h0, wb_v_o}, {72'h0, v[1]});
      if (v[3]) begin
         exp_q.push_back({1'b0, iwb_pkt_i});
         icnt++;
      end
      if (v[2]) begin
         exp_q.push_back({1'b1, fwb_pkt_i});
         fcnt++;
      end
      if (v[0]) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drop[%0d]: no packet held, expected one", k);
         end else begin
            void'(exp_q.pop_front());
         end
      end
   endtask

   // Delivery monitor: every accepted output packet must match the next queued expectation
   always @(negedge clk_i) begin
      if (!reset_i && wb_v_o === 1'b1 && wb_ready_and_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL deliver: unexpected packet fp=%b pkt=%h, expected none", wb_fp_o, wb_pkt_o);
         end else begin
            chk("deliver", {wb_fp_o, wb_pkt_o}, exp_q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // row bits: iv fv rdy flush | exp_iyumi exp_fyumi exp_wbv drop
      tbl = '{
         8'b1010_1000, 8'b0010_0010, 8'b0010_0000,                              // int only
         8'b1110_1000, 8'b1110_1010, 8'b1110_1010, 8'b1110_1010,                // contention
         8'b1110_0110, 8'b1110_1010, 8'b1110_1010,
         8'b1100_0010, 8'b1100_0010, 8'b1100_0010, 8'b1110_0110, 8'b1110_1010,  // backpressure
         8'b1100_0010, 8'b1100_0010, 8'b1100_0010, 8'b1101_0011,                // flush held
         8'b1110_1000, 8'b1111_0010, 8'b0010_0000,                              // flush with accept
         8'b1110_1000, 8'b1110_1010, 8'b1010_1010, 8'b1010_1010, 8'b1010_1010,  // FP withdraws
         8'b1110_1010, 8'b1110_1010, 8'b1110_1010, 8'b1110_1010, 8'b1010_1010,
         8'b0110_0110, 8'b1110_1010, 8'b0010_0010, 8'b0010_0000,
         8'b1110_1000, 8'b1100_0010, 8'b1100_0010, 8'b1100_0010,                // stall before reset
         8'b1110_1000, 8'b1110_1010, 8'b1110_1010, 8'b1110_1010, 8'b1110_0110,  // after reset
         8'b0010_0010, 8'b0010_0000
      };

      reset_i        = 1'b1;
      flush_i        = 1'b0;
      iwb_v_i        = 1'b1;
      fwb_v_i        = 1'b1;
      iwb_pkt_i      = '0;
      fwb_pkt_i      = '0;
      wb_ready_and_i = 1'b1;
      #2;
      chk("rst_wb_v", {72'h0, wb_v_o}, 73'h0);
      chk("rst_wb_pkt", {1'b0, wb_pkt_o}, 73'h0);
      chk("rst_wb_fp", {72'h0, wb_fp_o}, 73'h0);
      chk("rst_yumis", {71'h0, iwb_yumi_o, fwb_yumi_o}, 73'h0);
      iwb_v_i = 1'b0;
      fwb_v_i = 1'b0;
      @(negedge clk_i);
      reset_i = 1'b0;

      for (int k = 0; k < 40; k++) apply(k);

      // Mid-cycle asynchronous reset while a packet is held under backpressure
      #1;
      reset_i = 1'b1;
      #1;
      chk("async_rst_wb_v", {72'h0, wb_v_o}, 73'h0);
      chk("async_rst_wb_pkt", {1'b0, wb_pkt_o}, 73'h0);
      chk("async_rst_yumis", {71'h0, iwb_yumi_o, fwb_yumi_o}, 73'h0);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      iwb_v_i = 1'b0;
      fwb_v_i = 1'b0;
      wb_ready_and_i = 1'b1;
      @(negedge clk_i);
      #1;
      reset_i = 1'b0;

      for (int k = 40; k < 47; k++) apply(k);

      @(posedge clk_i);
      #2;
      chk("queue_empty", 73'(exp_q.size()), 73'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
